service_sequencer: RTL
======================

Name: service_sequencer

Overview:
- Downstream stage of the 8-input priority encoder.
- Holds eight sticky request bits. These bits drive the encoder's in0..in7 inputs.
- Consumes the encoder's num/any result and issues one grant at a time to a downstream service unit over a valid/ready handshake.
- Waits for done or a timeout, then clears the serviced bit so the encoder re-arbitrates on the remaining requests.

Parameters:
- N_REQ, 8: number of request channels; fixed at 8 to match the encoder.
- IDX_W, 3: width of the channel index (log2 N_REQ).
- TIMEOUT, 255: maximum cycles in BUSY before the grant is aborted; legal range 1..2^TO_W-1.
- TO_W, 8: width of the timeout counter.
- CNT_W, 16: width of the serviced-grant counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_in  in  N_REQ  request strobes; any high bit sets the matching pend bit.
- pend  out  N_REQ  sticky pending requests; bit k drives encoder in<k>.
- enc_num  in  IDX_W  encoder num output (combinational from pend).
- enc_any  in  1  encoder any output.
- grant_valid  out  1  grant offered to the service unit.
- grant_idx  out  IDX_W  channel being granted or serviced.
- grant_ready  in  1  service unit accepts the grant.
- done  in  1  service unit finished the current grant.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse when a grant is aborted by timeout.
- serviced_cnt  out  CNT_W  count of grants completed by done; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high): all outputs and registers are 0 on the cycle after reset is sampled high. This covers pend, grant_valid, grant_idx, busy, timeout_err, serviced_cnt, the timeout counter and the state (IDLE).
- Reset mid-operation: the grant is dropped immediately and pending requests are lost. Any req_in in the reset cycle is ignored.
- pend update, every cycle: pend_next = (pend & ~clr_mask) | req_in. clr_mask is one-hot at grant_idx in CLEAR and 0 otherwise.
- Set and clear of the same bit in one cycle: the set wins and the bit stays pending.
- FSM states: IDLE, ISSUE, BUSY, CLEAR.
- IDLE:
  - If enc_any=1, latch enc_num into grant_idx and go to ISSUE.
  - Otherwise stay in IDLE.
  - enc_num is sampled from the current pend, so the encoder's priority order (highest index first) is honoured.
- ISSUE:
  - grant_valid=1 while in this state; grant_idx stays stable.
  - On grant_ready=1, go to BUSY and clear the timeout counter.
  - grant_valid drops the cycle after acceptance.
  - No timeout applies in ISSUE.
  - done is ignored in ISSUE.
- BUSY:
  - The timeout counter increments each cycle.
  - done=1: go to CLEAR; serviced_cnt += 1, saturating.
  - Otherwise, if the counter equals TIMEOUT-1: go to CLEAR and pulse timeout_err for one cycle; serviced_cnt is unchanged.
  - done in the same cycle as the timeout boundary: done wins, no error.
- CLEAR:
  - One cycle; pend[grant_idx] is cleared (subject to set-wins), then go to IDLE.
  - This cycle lets the encoder settle on the new pend before IDLE samples it.
- Latency: request strobe to grant_valid is 2 cycles from IDLE (pend registers, then IDLE latches, then ISSUE). After a grant finishes, the earliest next grant_valid is 3 cycles after done (CLEAR, IDLE, ISSUE).
- Widths: timeout counter is TO_W bits and never wraps, because its exit is at TIMEOUT-1. serviced_cnt holds at 2^CNT_W-1.
- Requests for a channel that is already pending merge into the single sticky bit; there is no queue depth per channel.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, ISSUE, BUSY, CLEAR).
  - N_REQ and IDX_W constants, shared with the encoder instantiation.
  - A default TIMEOUT constant.
- The priority encoder stays a separate, externally instantiated module; the block exposes pend and consumes enc_num/enc_any.
- One natural sub-module: sticky_req_reg, covering the pend register with set-wins clear.

Test Plan:
- Reset and basic grant: reset for 2 cycles, then req_in=0x08 for 1 cycle → pend=0x08; grant_valid=1 with grant_idx=3 two cycles later. Then grant_ready=1 and done 4 cycles later → pend=0x00, serviced_cnt=1, busy=0 after CLEAR.
- Priority order: req_in=0x85 in one cycle → grants issued with grant_idx 7, then 2, then 0, in that order. pend goes 0x85→0x05→0x01→0x00.
- Timeout: TIMEOUT=4, grant accepted, done never asserted → timeout_err pulses exactly 4 cycles after entering BUSY; serviced_cnt is unchanged; the bit is cleared.
- Set-wins collision: req_in bit 5 high in the CLEAR cycle of a channel-5 grant → pend[5] stays 1 and a second grant with grant_idx=5 follows.
- Backpressure: grant_ready held low for 10 cycles → grant_valid and grant_idx stay stable throughout, no timeout_err; a done pulse during ISSUE is ignored.
- Reset mid-BUSY: reset asserted during BUSY → next cycle state is IDLE and all outputs are 0, including pend and serviced_cnt.

Source files
------------

// File: rtl/service_sequencer_pkg.sv
// Shared definitions for the service sequencer and its encoder hookup.
// - state_e         : sequencer FSM states
// - N_REQ / IDX_W   : request channel count and index width (match the encoder)
// - DEFAULT_TIMEOUT : default BUSY abort limit in cycles
package service_sequencer_pkg;

  localparam int unsigned N_REQ           = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StBusy,
    StClear
  } state_e;

endpackage

// File: rtl/sticky_req_reg.sv
// Sticky pending-request register.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset, clears every pending bit
//   set   - request strobes, one per channel
//   clr   - clear mask (one-hot or zero)
//   pend  - registered pending bits
// A bit that is set and cleared in the same cycle stays pending.
module sticky_req_reg
  import service_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] set,
  input  logic [N_REQ-1:0] clr,
  output logic [N_REQ-1:0] pend
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | set;
    end
  end

endmodule

// File: rtl/service_sequencer.sv
// Service sequencer: holds sticky requests that feed an external 8-input
// priority encoder, then issues the encoder's winner as a single grant over a
// valid/ready handshake, waits for done or a timeout, and clears the serviced
// channel so the encoder re-arbitrates.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   req_in       - request strobes (set pend bits)
//   pend         - sticky pending requests, bit k drives encoder in<k>
//   enc_num      - encoder index of highest pending request
//   enc_any      - encoder reports at least one pending request
//   grant_valid  - grant offered; grant_idx is the granted channel
//   grant_ready  - service unit accepts the grant
//   done         - service unit finished the current grant
//   busy         - high outside IDLE
//   timeout_err  - one-cycle pulse when a grant is aborted by timeout
//   serviced_cnt - saturating count of grants completed by done
module service_sequencer
  import service_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_in,
  output logic [N_REQ-1:0] pend,
  input  logic [IDX_W-1:0] enc_num,
  input  logic             enc_any,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  input  logic             grant_ready,
  input  logic             done,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] serviced_cnt
);

  // Counter exits at TIMEOUT-1, so it never needs to wrap.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [N_REQ-1:0] clr_mask;

  assign clr_mask = (state_q == StClear) ? (N_REQ'(1) << grant_idx) : '0;

  sticky_req_reg u_sticky_req_reg (
    .clk   (clk),
    .reset (reset),
    .set   (req_in),
    .clr   (clr_mask),
    .pend  (pend)
  );

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      to_cnt_q     <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      serviced_cnt <= '0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (enc_any) begin
            grant_idx   <= enc_num;
            grant_valid <= 1'b1;
            busy        <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          // No timeout and done is ignored until the grant is accepted.
          if (grant_ready) begin
            grant_valid <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= StBusy;
          end
        end
        StBusy: begin
          if (done) begin
            if (serviced_cnt != '1) begin
              serviced_cnt <= serviced_cnt + CNT_W'(1);
            end
            state_q <= StClear;
          end else if (to_cnt_q == ToLast) begin
            timeout_err <= 1'b1;
            state_q     <= StClear;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        StClear: begin
          // pend bit clears this cycle; IDLE then samples the settled encoder.
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
